// File: rtl/exec_pkg.sv
// Shared types for the pipelined execution unit.
// The stage bundle is sized for the widest supported configuration.
package exec_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREG_DEF   = 32;
    localparam int DW_MAX     = 64;
    localparam int AW_MAX     = 8;
    localparam int SW_MAX     = 6;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_SLT = 4'd9
    } op_t;

    typedef struct packed {
        logic              valid;
        op_t               op;
        logic [AW_MAX-1:0] rd;
        logic [AW_MAX-1:0] rs;
        logic [AW_MAX-1:0] rt;
        logic [SW_MAX-1:0] shamt;
        logic              use_shamt;
        logic [DW_MAX-1:0] a;
        logic [DW_MAX-1:0] b;
    } stage_t;

endpackage

// File: rtl/pipelined_exec_unit_alu.sv
// Combinational ALU: result, zero flag and signed overflow for ADD/SUB.
module exec_alu
    import exec_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    localparam int SW     = $clog2(DATA_W)
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SW-1:0]     sh,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              ovf
);

    localparam int M = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              slt;

    always_comb begin
        sum    = a + b;
        diff   = a - b;
        slt    = $signed(a) < $signed(b);
        result = '0;
        ovf    = 1'b0;
        unique case (op)
            OP_ADD: begin
                result = sum;
                ovf    = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SLL:  result = b << sh;
            OP_SRL:  result = b >> sh;
            OP_SRA:  result = $unsigned($signed(b) >>> sh);
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, slt};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/pipelined_exec_unit.sv
// Three-stage execution unit with register file, accept bypass and
// EX forwarding from R2/R3; a single global advance stalls everything.
module pipelined_exec_unit
    import exec_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREG   = NREG_DEF,
    localparam int AW     = $clog2(NREG),
    localparam int SW     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic [SW-1:0]     in_shamt,
    input  logic              in_use_shamt,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [AW-1:0]     res_rd,
    output logic              res_zero,
    output logic              res_ovf
);

    stage_t            r1;
    logic              r2_valid;
    logic [AW-1:0]     r2_rd;
    logic [DATA_W-1:0] r2_data;
    logic              r2_zero;
    logic              r2_ovf;
    logic              r3_valid;
    logic [DATA_W-1:0] rf [NREG];

    logic              advance;
    logic              accept;
    logic              retire;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [AW-1:0]     ex_rs;
    logic [AW-1:0]     ex_rt;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [SW-1:0]     ex_sh;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;
    logic              alu_ovf;
    logic              unused_hi;

    assign advance   = !(r3_valid && !res_ready);
    assign in_ready  = advance && !ld_en;
    assign accept    = in_valid && in_ready;
    assign retire    = r3_valid && res_ready;
    assign ld_ready  = !r1.valid && !r2_valid && !r3_valid && !in_valid;
    assign res_valid = r3_valid;

    // Upper bits of the max-width bundle are don't-care here.
    assign unused_hi = ^{r1.a, r1.b, r1.rd, r1.rs, r1.rt, r1.shamt};

    always_comb begin
        cap_a = rf[in_rs];
        cap_b = rf[in_rt];
        if (retire && res_rd == in_rs && in_rs != '0) cap_a = res_data;
        if (retire && res_rd == in_rt && in_rt != '0) cap_b = res_data;
    end

    always_comb begin
        ex_rs = r1.rs[AW-1:0];
        ex_rt = r1.rt[AW-1:0];
        ex_a  = r1.a[DATA_W-1:0];
        ex_b  = r1.b[DATA_W-1:0];
        // R3 first so that a younger R2 match overrides it.
        if (r3_valid && res_rd == ex_rs && ex_rs != '0) ex_a = res_data;
        if (r2_valid && r2_rd == ex_rs && ex_rs != '0) ex_a = r2_data;
        if (r3_valid && res_rd == ex_rt && ex_rt != '0) ex_b = res_data;
        if (r2_valid && r2_rd == ex_rt && ex_rt != '0) ex_b = r2_data;
        ex_sh = r1.use_shamt ? r1.shamt[SW-1:0] : ex_a[SW-1:0];
    end

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (r1.op),
        .a      (ex_a),
        .b      (ex_b),
        .sh     (ex_sh),
        .result (alu_res),
        .zero   (alu_zero),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1       <= '0;
            r2_valid <= 1'b0;
            r2_rd    <= '0;
            r2_data  <= '0;
            r2_zero  <= 1'b0;
            r2_ovf   <= 1'b0;
            r3_valid <= 1'b0;
            res_rd   <= '0;
            res_data <= '0;
            res_zero <= 1'b0;
            res_ovf  <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (retire && res_rd != '0)
                rf[res_rd] <= res_data;
            else if (ld_en && ld_ready && ld_addr != '0)
                rf[ld_addr] <= ld_data;
            if (advance) begin
                r1.valid <= accept;
                if (accept) begin
                    r1.op        <= op_t'(in_op);
                    r1.rd        <= AW_MAX'(in_rd);
                    r1.rs        <= AW_MAX'(in_rs);
                    r1.rt        <= AW_MAX'(in_rt);
                    r1.shamt     <= SW_MAX'(in_shamt);
                    r1.use_shamt <= in_use_shamt;
                    r1.a         <= DW_MAX'(cap_a);
                    r1.b         <= DW_MAX'(cap_b);
                end
                r2_valid <= r1.valid;
                r2_rd    <= r1.rd[AW-1:0];
                r2_data  <= alu_res;
                r2_zero  <= alu_zero;
                r2_ovf   <= alu_ovf;
                r3_valid <= r2_valid;
                res_rd   <= r2_rd;
                res_data <= r2_data;
                res_zero <= r2_zero;
                res_ovf  <= r2_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_exec_unit.sv
// Scoreboard bench: issue side pushes expected results, a negedge
// monitor pops and compares on every retire.
module tb_pipelined_exec_unit;
    import exec_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [AW-1:0] in_rd = '0;
    logic [AW-1:0] in_rs = '0;
    logic [AW-1:0] in_rt = '0;
    logic [SW-1:0] in_shamt = '0;
    logic          in_use_shamt = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_rd;
    logic          res_zero;
    logic          res_ovf;

    always #5 clk = ~clk;

    pipelined_exec_unit #(.DATA_W(DW), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_shamt(in_shamt), .in_use_shamt(in_use_shamt),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rd(res_rd),
        .res_zero(res_zero), .res_ovf(res_ovf)
    );

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
        logic          z;
        logic          o;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_result: got rd=%0d data=%0h required none",
                         res_rd, res_data);
            end else begin
                chk("res_rd", 64'(res_rd), 64'(sbq[0].rd));
                chk("res_data", 64'(res_data), 64'(sbq[0].d));
                chk("res_zero", 64'(res_zero), 64'(sbq[0].z));
                chk("res_ovf", 64'(res_ovf), 64'(sbq[0].o));
                if (!res_ready) begin
                    chk("in_ready_stall", 64'(in_ready), 64'd0);
                end else begin
                    if (sbq[0].cyc >= 0)
                        chk("latency", 64'(cyc), 64'(sbq[0].cyc));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input int rd, input int rs,
                         input int rt, input int sh, input logic use_sh,
                         input logic [DW-1:0] d, input logic o,
                         input bit lat, input bit push);
        int   n;
        exp_t e;
        n = 0;
        in_valid     = 1'b1;
        in_op        = op;
        in_rd        = rd[AW-1:0];
        in_rs        = rs[AW-1:0];
        in_rt        = rt[AW-1:0];
        in_shamt     = sh[SW-1:0];
        in_use_shamt = use_sh;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                e.rd  = rd[AW-1:0];
                e.d   = d;
                e.z   = (d == '0);
                e.o   = o;
                e.cyc = lat ? cyc + 3 : -1;
                if (push) sbq.push_back(e);
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready 0 for %0d cycles, required 1", n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic preload(input int addr, input logic [DW-1:0] d);
        int n;
        n = 0;
        ld_en   = 1'b1;
        ld_addr = addr[AW-1:0];
        ld_data = d;
        while (1) begin
            @(negedge clk);
            if (ld_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL preload_timeout: ld_ready 0 for %0d cycles, required 1", n);
                break;
            end
        end
        ld_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drained", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running, required completion");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // forwarding chain: R2, R3, accept bypass, R2-over-R3 priority
        preload(1, 32'd5);
        preload(2, 32'd7);
        issue(OP_ADD, 3, 1, 2, 0, 0, 32'd12, 0, 1, 1);
        issue(OP_SUB, 4, 3, 1, 0, 0, 32'd7,  0, 1, 1);
        issue(OP_AND, 5, 4, 3, 0, 0, 32'd4,  0, 1, 1);
        issue(OP_ADD, 8, 3, 1, 0, 0, 32'd17, 0, 1, 1);
        issue(OP_ADD, 8, 8, 1, 0, 0, 32'd22, 0, 1, 1);
        issue(OP_ADD, 9, 8, 0, 0, 0, 32'd22, 0, 1, 1);

        // overflow and zero flags
        preload(1, 32'h7FFF_FFFF);
        issue(OP_ADD, 2, 1, 1, 0, 0, 32'hFFFF_FFFE, 1, 1, 1);
        issue(OP_SUB, 3, 2, 2, 0, 0, 32'h0, 0, 1, 1);

        // shifts, SLT, NOR, unused opcode
        preload(1, 32'hF000_0000);
        preload(6, 32'd3);
        issue(OP_SRA, 2, 0, 1, 4, 1, 32'hFF00_0000, 0, 1, 1);
        issue(OP_SRL, 3, 6, 1, 0, 0, 32'h1E00_0000, 0, 1, 1);
        issue(OP_SLT, 4, 1, 6, 0, 0, 32'd1, 0, 1, 1);
        issue(OP_SLL, 10, 6, 6, 0, 0, 32'd24, 0, 1, 1);
        issue(OP_NOR, 7, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 1, 1);
        issue(4'd12, 8, 1, 6, 0, 0, 32'h0, 0, 1, 1);

        // register 0
        preload(1, 32'd2);
        preload(0, 32'd9);
        issue(OP_ADD, 0, 1, 1, 0, 0, 32'd4, 0, 1, 1);
        issue(OP_ADD, 5, 0, 0, 0, 0, 32'd0, 0, 1, 1);
        drain();
        issue(OP_ADD, 11, 0, 0, 0, 0, 32'd0, 0, 1, 1);

        // backpressure during a dependent stream
        preload(1, 32'd1);
        fork
            begin
                issue(OP_ADD, 7,  1,  1,  0, 0, 32'd2, 0, 0, 1);
                issue(OP_ADD, 8,  7,  1,  0, 0, 32'd3, 0, 0, 1);
                issue(OP_ADD, 9,  8,  7,  0, 0, 32'd5, 0, 0, 1);
                issue(OP_SUB, 10, 9,  1,  0, 0, 32'd4, 0, 0, 1);
                issue(OP_XOR, 11, 10, 9,  0, 0, 32'd1, 0, 0, 1);
                issue(OP_OR,  12, 11, 8,  0, 0, 32'd3, 0, 0, 1);
            end
            begin
                repeat (2) @(posedge clk);
                #1 res_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        drain();
        issue(OP_ADD, 13, 7,  8,  0, 0, 32'd5, 0, 1, 1);
        issue(OP_ADD, 14, 9,  10, 0, 0, 32'd9, 0, 1, 1);
        issue(OP_ADD, 15, 11, 12, 0, 0, 32'd4, 0, 1, 1);
        drain();

        // reset with three instructions in flight
        issue(OP_ADD, 16, 1,  1, 0, 0, 32'd0, 0, 0, 0);
        issue(OP_ADD, 17, 16, 1, 0, 0, 32'd0, 0, 0, 0);
        issue(OP_ADD, 18, 17, 1, 0, 0, 32'd0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_res_data", 64'(res_data), 64'd0);
        chk("midrst_res_rd", 64'(res_rd), 64'd0);
        chk("midrst_flags", 64'({res_zero, res_ovf}), 64'd0);
        chk("midrst_ld_ready", 64'(ld_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        issue(OP_ADD, 20, 1,  0, 0, 0, 32'd0, 0, 1, 1);
        issue(OP_ADD, 21, 6,  6, 0, 0, 32'd0, 0, 1, 1);
        issue(OP_OR,  22, 12, 9, 0, 0, 32'd0, 0, 1, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
